// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter with a one-hot rotating priority pointer.
// Each grant is held until the owner pulses done, drops its request, or
// the optional hold limit expires. The pointer moves one past the owner
// whenever a grant is released, so every requester is eventually served.
module ring_rr_arbiter #(
  parameter  int N        = 8,
  parameter  int MAX_HOLD = 16,
  localparam int IW       = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable_i,
  input  logic [N-1:0]  req_i,
  input  logic [N-1:0]  done_i,
  output logic [N-1:0]  grant_o,
  output logic          grant_valid_o,
  output logic [IW-1:0] grant_id_o,
  output logic [N-1:0]  ptr_o,
  output logic          preempt_o
);

  // The hold counter must count up to MAX_HOLD; keep it at least one bit wide
  // so the limit-disabled configuration still elaborates.
  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic          grant_valid_q, grant_valid_d;
  logic [IW-1:0] grant_id_q, grant_id_d;
  logic [N-1:0]  ptr_q, ptr_d;
  logic          preempt_q, preempt_d;
  logic [HW-1:0] hold_q, hold_d;

  // Circular priority search: requests at or above the pointer win; if none,
  // fall back to the lowest request overall, which is the wrap-around case.
  logic [N-1:0]  req_upper;
  logic [N-1:0]  search_vec;
  logic [N-1:0]  sel_onehot;
  logic [IW-1:0] sel_id;
  logic          owner_done;
  logic          owner_req;
  logic          hold_expired;
  logic          release_now;

  assign req_upper    = req_i & ~(ptr_q - N'(1));
  assign search_vec   = (req_upper != '0) ? req_upper : req_i;
  assign sel_onehot   = search_vec & (~search_vec + N'(1));
  assign owner_done   = |(done_i & grant_q);
  assign owner_req    = |(req_i & grant_q);
  assign hold_expired = (MAX_HOLD != 0) && (hold_q == HW'(MAX_HOLD));
  assign release_now  = owner_done || !owner_req || hold_expired;

  // Binary encoding of the selected one-hot requester.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch so no latch is inferred.
    sel_id = '0;
    for (int i = 0; i < N; i++) begin
      if ((sel_onehot & (N'(1) << i)) != '0) sel_id = IW'(i);
    end
  end

  // State register: all arbiter state, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q       <= IDLE;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      ptr_q         <= N'(1);
      preempt_q     <= 1'b0;
      hold_q        <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      grant_id_q    <= grant_id_d;
      ptr_q         <= ptr_d;
      preempt_q     <= preempt_d;
      hold_q        <= hold_d;
    end
  end

  // Next-state logic: issue grants from IDLE, apply release rules in GRANT.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    grant_valid_d = grant_valid_q;
    grant_id_d    = grant_id_q;
    ptr_d         = ptr_q;
    preempt_d     = 1'b0;
    hold_d        = hold_q;
    unique case (state_q)
      IDLE: begin
        if (enable_i && (req_i != '0)) begin
          state_d       = GRANT;
          grant_d       = sel_onehot;
          grant_valid_d = 1'b1;
          grant_id_d    = sel_id;
          hold_d        = HW'(1);
        end
      end
      GRANT: begin
        if (release_now) begin
          state_d       = IDLE;
          grant_d       = '0;
          grant_valid_d = 1'b0;
          ptr_d         = {grant_q[N-2:0], grant_q[N-1]};
          preempt_d     = hold_expired && !owner_done && owner_req;
          hold_d        = '0;
        end else begin
          hold_d        = hold_q + HW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs come straight from registers.
  always_comb begin
    grant_o       = grant_q;
    grant_valid_o = grant_valid_q;
    grant_id_o    = grant_id_q;
    ptr_o         = ptr_q;
    preempt_o     = preempt_q;
  end

endmodule

// File: doc/ring_rr_arbiter.md
# ring_rr_arbiter

Round-robin arbiter that shares one resource among up to N requesters. Priority is held in a one-hot ring pointer that rotates past each served requester, so no requester starves. Each grant is held until the owner releases it or a hold limit expires. The block sits in front of any shared datapath and drives its select lines from the one-hot `grant`.

## Interface
- `N`, default 8: number of requesters; legal range 2..16.
- `MAX_HOLD`, default 16: maximum grant length in cycles before forced release; 0 disables the limit.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `enable`  in  1  allows new grants; does not affect a grant already issued.
- `req`  in  N  request per requester; level, held for as long as access is wanted.
- `done`  in  N  release strobe per requester; only the bit of the current owner is honoured.
- `grant`  out  N  one-hot grant, registered; all zeros when idle.
- `grant_valid`  out  1  equals |grant, registered.
- `grant_id`  out  $clog2(N)  binary index of the owner; holds its last value when idle.
- `ptr`  out  N  one-hot priority pointer; its set bit is the highest-priority index.
- `preempt`  out  1  one-cycle pulse after a grant is forcibly released by MAX_HOLD.

## Operation
- States: IDLE and GRANT. A hold counter of width $clog2(MAX_HOLD+1) runs in GRANT.
- Reset values:
  - state = IDLE
  - grant = 0, grant_valid = 0, grant_id = 0
  - ptr = 1 (bit 0)
  - preempt = 0, hold counter = 0
- IDLE to GRANT happens on the edge where enable = 1 and req != 0.
  - Selected requester: the first set req bit scanning circularly from the ptr position upward, wrapping from N-1 to 0.
  - At that edge: grant = one-hot of the selected bit, grant_id = its index, hold counter = 1.
- While in GRANT, req and done bits of non-owners are ignored, and the hold counter increments every cycle.
- GRANT to IDLE (release) happens on the first edge where any of these is true:
  - done[id] = 1;
  - req[id] = 0;
  - MAX_HOLD != 0 and the hold counter = MAX_HOLD (forced release).
- At the release edge: grant = 0, ptr = grant rotated left by one (bit N-1 wraps to bit 0).
  - preempt = 1 only if the release is forced and neither done[id] nor a req drop is also present.
  - preempt returns to 0 on the next edge.
- ptr changes only at release edges; it never changes in IDLE.
- enable = 0 in GRANT does not cut the grant short; the normal release rules still apply.
- At most one grant bit is ever set.

## Timing
- Request to grant: req sampled at edge t (IDLE, enable = 1) gives grant visible from t+1.
- A release at edge t clears grant at t+1. The next grant can come no sooner than the edge after, so there is a mandatory one-cycle idle gap between owners.
- A forced grant lasts exactly MAX_HOLD cycles.
- Minimum grant length is 1 cycle, when done is asserted in the first GRANT cycle.
- Asserting rst_n low at any time, including mid-grant, immediately forces every output to its reset value.
- Deasserting reset is synchronous to clk. The first grant is possible at the first edge after release.

## Test plan
- Reset, N = 8: hold rst_n low, then release it → grant = 0x00, grant_valid = 0, ptr = 0x01, preempt = 0.
- Full rotation: req = 0xFF held, each owner pulses done in its first grant cycle → grants 0x01, 0x02, 0x04 … 0x80, then 0x01, each separated by one idle cycle; ptr ends at 0x02.
- Wrap search: grant 0x08, then release so ptr = 0x10; apply req = 0x09 → next grant 0x01, grant_id = 0, ptr = 0x02 after release.
- Forced release, MAX_HOLD = 4: req = 0x24 with ptr = 0x04, no done → grant 0x04 for exactly 4 cycles, then preempt pulses once, ptr = 0x08, next grant 0x20.
- Request drop and enable: grant 0x02, then drop req[1] → grant = 0 at the next edge and ptr = 0x04. Hold enable = 0 with req = 0xFF → no grant until enable = 1.
- Mid-grant reset: assert rst_n low while grant = 0x40 → grant = 0 and ptr = 0x01 asynchronously, before the next clk edge.
